// File: rtl/sat_acc_pkg.sv
// Shared opcode encodings and command field positions for the bit-parallel
// CNF satisfiability checker.
package sat_acc_pkg;

  localparam logic [1:0] OP_RESET      = 2'b00;
  localparam logic [1:0] OP_CLAUSE     = 2'b01;
  localparam logic [1:0] OP_CNF        = 2'b10;
  localparam logic [1:0] OP_CLR_CLAUSE = 2'b11;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int VAR_MSB = 5;
  localparam int VAR_LSB = 1;
  localparam int NEG_BIT = 0;

  function automatic logic [7:0] mk_cmd(logic [1:0] op, logic [4:0] var_pos, logic neg);
    return {op, var_pos, neg};
  endfunction

endpackage

// File: rtl/sat_literal_mask.sv
// Truth-table mask of one literal over all 2^N assignments; bit j is
// bit var_pos of j, optionally inverted. Out-of-range variables give zero.
module sat_literal_mask #(
  parameter int N = 4
) (
  input  logic [4:0]        varPos,
  input  logic              negCtrl,
  output logic [(1<<N)-1:0] mask
);
  localparam int W = 1 << N;

  logic in_range;
  assign in_range = (varPos < 5'(N));

  for (genvar j = 0; j < W; j++) begin : g_bit
    localparam logic [7:0] JV = 8'(j);
    // only the low 3 bits matter once in_range holds (N <= 8)
    assign mask[j] = in_range & (JV[varPos[2:0]] ^ negCtrl);
  end

endmodule

// File: rtl/sat_accelerator_top.sv
// Command-driven CNF checker: ORs literal masks into a clause, ANDs clauses
// into the CNF vector and registers whether any assignment survives.
module sat_accelerator_top
  import sat_acc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] command,
  output logic       outSATRes
);
  localparam int W = 1 << N;

  logic [1:0]   opc;
  logic [4:0]   var_pos;
  logic         neg;
  logic [W-1:0] lit;
  logic [W-1:0] clause_q;
  logic [W-1:0] cnf_q;
  logic [W-1:0] cnf_next;

  assign opc      = command[OPC_MSB:OPC_LSB];
  assign var_pos  = command[VAR_MSB:VAR_LSB];
  assign neg      = command[NEG_BIT];
  assign cnf_next = cnf_q & clause_q;

  sat_literal_mask #(.N(N)) u_mask (
    .varPos (var_pos),
    .negCtrl(neg),
    .mask   (lit)
  );

  // resetN is active-high despite its name
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      clause_q  <= '0;
      cnf_q     <= '1;
      outSATRes <= 1'b0;
    end else begin
      case (opc)
        OP_RESET: begin
          clause_q  <= '0;
          cnf_q     <= '1;
          outSATRes <= 1'b0;
        end
        OP_CLAUSE:     clause_q <= clause_q | lit;
        OP_CNF: begin
          cnf_q     <= cnf_next;
          outSATRes <= |cnf_next;
        end
        OP_CLR_CLAUSE: clause_q <= '0;
        default:       clause_q <= clause_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_accelerator_top.sv
// Directed bench for sat_accelerator_top: N=4 scenarios plus an N=1/2/8 sweep
// sharing one command stream, with hand-computed truth-table vectors.
module tb_sat_accelerator_top;
  import sat_acc_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] command;
  logic       sat4, sat1, sat2, sat8;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  sat_accelerator_top #(.N(4)) dut4 (.clk(clk), .resetN(resetN), .command(command), .outSATRes(sat4));
  sat_accelerator_top #(.N(1)) dut1 (.clk(clk), .resetN(resetN), .command(command), .outSATRes(sat1));
  sat_accelerator_top #(.N(2)) dut2 (.clk(clk), .resetN(resetN), .command(command), .outSATRes(sat2));
  sat_accelerator_top #(.N(8)) dut8 (.clk(clk), .resetN(resetN), .command(command), .outSATRes(sat8));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one command, let it be sampled, return 1 time unit after the edge
  task automatic send(input logic [1:0] op, input logic [4:0] v, input logic n);
    command = mk_cmd(op, v, n);
    @(posedge clk);
    #1;
  endtask

  task automatic sat_scenario(input string pfx);
    send(OP_RESET, 5'd0, 1'b0);
    send(OP_CLAUSE, 5'd0, 1'b0);
    send(OP_CLAUSE, 5'd1, 1'b0);
    chk({pfx, "_clause_x1x2"}, 256'(dut4.clause_q), 256'h0000_EEEE);
    send(OP_CNF, 5'd0, 1'b0);
    chk({pfx, "_cnf1"}, 256'(dut4.cnf_q), 256'hEEEE);
    chk({pfx, "_sat1"}, 256'(sat4), 256'd1);
    send(OP_CLR_CLAUSE, 5'd0, 1'b0);
    chk({pfx, "_clr"}, 256'(dut4.clause_q), 256'd0);
    send(OP_CLAUSE, 5'd0, 1'b1);
    send(OP_CLAUSE, 5'd1, 1'b0);
    chk({pfx, "_clause_nx1x2"}, 256'(dut4.clause_q), 256'hDDDD);
    send(OP_CNF, 5'd0, 1'b0);
    chk({pfx, "_cnf2"}, 256'(dut4.cnf_q), 256'hCCCC);
    chk({pfx, "_sat2"}, 256'(sat4), 256'd1);
  endtask

  initial begin
    logic [255:0] alt8;
    alt8    = {128{2'b10}};
    resetN  = 1'b1;
    command = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sat",    256'(sat4), 256'd0);
    chk("rst_cnf",    256'(dut4.cnf_q), 256'hFFFF);
    chk("rst_clause", 256'(dut4.clause_q), 256'd0);
    resetN = 1'b0;

    // parameter sweep: single clause x1
    send(OP_CLAUSE, 5'd0, 1'b0);
    send(OP_CNF, 5'd0, 1'b0);
    chk("sweep_cnf1", 256'(dut1.cnf_q), 256'b10);
    chk("sweep_sat1", 256'(sat1), 256'd1);
    chk("sweep_cnf2", 256'(dut2.cnf_q), 256'hA);
    chk("sweep_sat2", 256'(sat2), 256'd1);
    chk("sweep_cnf4", 256'(dut4.cnf_q), 256'hAAAA);
    chk("sweep_sat4", 256'(sat4), 256'd1);
    chk("sweep_cnf8", dut8.cnf_q, alt8);
    chk("sweep_sat8", 256'(sat8), 256'd1);

    sat_scenario("sat");

    // unsatisfiable (x1)(~x1), then a further clause cannot revive it
    send(OP_RESET, 5'd0, 1'b0);
    send(OP_CLAUSE, 5'd0, 1'b0);
    send(OP_CNF, 5'd0, 1'b0);
    send(OP_CLR_CLAUSE, 5'd0, 1'b0);
    send(OP_CLAUSE, 5'd0, 1'b1);
    chk("unsat_clause_nx1", 256'(dut4.clause_q), 256'h5555);
    send(OP_CNF, 5'd0, 1'b0);
    chk("unsat_cnf", 256'(dut4.cnf_q), 256'd0);
    chk("unsat_sat", 256'(sat4), 256'd0);
    send(OP_CLR_CLAUSE, 5'd0, 1'b0);
    send(OP_CLAUSE, 5'd1, 1'b0);
    send(OP_CNF, 5'd0, 1'b0);
    chk("unsat_sticky_cnf", 256'(dut4.cnf_q), 256'd0);
    chk("unsat_sticky_sat", 256'(sat4), 256'd0);

    // out-of-range literal (both polarities) leaves the clause empty
    send(OP_RESET, 5'd0, 1'b0);
    send(OP_CLAUSE, 5'd5, 1'b0);
    send(OP_CLAUSE, 5'd5, 1'b1);
    chk("oor_clause", 256'(dut4.clause_q), 256'd0);
    send(OP_CNF, 5'd0, 1'b0);
    chk("oor_cnf", 256'(dut4.cnf_q), 256'd0);
    chk("oor_sat", 256'(sat4), 256'd0);

    // idle stream of RESET commands
    for (int i = 0; i < 3; i++) begin
      send(OP_RESET, 5'd0, 1'b0);
      chk("idle_sat", 256'(sat4), 256'd0);
      chk("idle_cnf", 256'(dut4.cnf_q), 256'hFFFF);
    end

    // async reset between two clause commands, away from a clock edge
    send(OP_CLAUSE, 5'd0, 1'b0);
    send(OP_CNF, 5'd0, 1'b0);
    send(OP_CLR_CLAUSE, 5'd0, 1'b0);
    send(OP_CLAUSE, 5'd0, 1'b1);
    chk("pre_async_sat", 256'(sat4), 256'd1);
    #3 resetN = 1'b1;
    #1;
    chk("async_sat",    256'(sat4), 256'd0);
    chk("async_cnf",    256'(dut4.cnf_q), 256'hFFFF);
    chk("async_clause", 256'(dut4.clause_q), 256'd0);
    command = mk_cmd(OP_CLAUSE, 5'd1, 1'b0);
    @(posedge clk);
    #1;
    chk("async_hold_clause", 256'(dut4.clause_q), 256'd0);
    resetN = 1'b0;
    sat_scenario("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
